// File: rtl/riscv_core_divider.sv
`timescale 1ns/1ps
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Optional build macro DIV_EARLY_OUT_EN finishes |dividend| < |divisor| cases in one cycle.
module riscv_core_divider #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_start,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic [1:0]      i_div_op,
    input  logic            i_div_isword,
    input  logic            i_div_flush,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CNT_W = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_is_rem;
    logic            r_isword;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_early;
    logic            w_special;
    logic [XLEN-1:0] w_special_raw;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quot_next;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_final_raw;
    logic [XLEN-1:0] w_final;
    logic            w_last;

    // Operand conditioning at the start edge: W ops see only bits [31:0].
    // NOTE: every signal assigned in always_comb gets a value on all paths, or a latch is inferred.
    always_comb begin
        w_signed = ~i_div_op[0];
        w_a_ext  = i_div_srcA;
        w_b_ext  = i_div_srcB;
        if (i_div_isword) begin
            w_a_ext = w_signed ? sext32(i_div_srcA) : {{(XLEN-32){1'b0}}, i_div_srcA[31:0]};
            w_b_ext = w_signed ? sext32(i_div_srcB) : {{(XLEN-32){1'b0}}, i_div_srcB[31:0]};
        end
        w_a_neg = w_signed & w_a_ext[XLEN-1];
        w_b_neg = w_signed & w_b_ext[XLEN-1];
        w_a_mag = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
        w_b_mag = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;
        w_min   = i_div_isword ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    end

    // RISC-V defined corner results, resolved without iterating.
    always_comb begin
        w_b_zero = (w_b_ext == '0);
        w_ovf    = w_signed && (w_a_ext == w_min) && (w_b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
        w_early  = !w_b_zero && (w_a_mag < w_b_mag);
`else
        w_early  = 1'b0;
`endif
        w_special     = w_b_zero | w_ovf | w_early;
        w_special_raw = '0;
        if (w_b_zero)
            w_special_raw = i_div_op[1] ? w_a_ext : '1;
        else if (w_ovf)
            w_special_raw = i_div_op[1] ? '0 : w_a_ext;
        else if (w_early)
            w_special_raw = i_div_op[1] ? w_a_ext : '0;
        w_special_res = i_div_isword ? sext32(w_special_raw) : w_special_raw;
    end

    // One restoring step; the final step also feeds the sign fix-up directly.
    always_comb begin
        w_rem_sh    = {r_rem, r_quot[XLEN-1]};
        w_ge        = (w_rem_sh >= {1'b0, r_divisor});
        w_rem_next  = w_ge ? (w_rem_sh[XLEN-1:0] - r_divisor) : w_rem_sh[XLEN-1:0];
        w_quot_next = {r_quot[XLEN-2:0], w_ge};
        w_q_fix     = r_neg_q ? (~w_quot_next + 1'b1) : w_quot_next;
        w_r_fix     = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
        w_final_raw = r_is_rem ? w_r_fix : w_q_fix;
        w_final     = r_isword ? sext32(w_final_raw) : w_final_raw;
        w_last      = (r_cnt == (r_isword ? CNT_W'(31) : CNT_W'(XLEN-1)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_rem  <= 1'b0;
            r_isword  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_div_flush && i_div_start) begin
                        r_is_rem  <= i_div_op[1];
                        r_isword  <= i_div_isword;
                        r_neg_q   <= w_signed & (w_a_neg ^ w_b_neg);
                        r_neg_r   <= w_signed & w_a_neg;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        // W dividends start at the top so 32 shifts leave the quotient in [31:0].
                        r_quot    <= i_div_isword ? (w_a_mag << (XLEN-32)) : w_a_mag;
                        r_cnt     <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (i_div_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= w_final;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_div_busy   = (r_state != S_IDLE);
    assign o_div_valid  = (r_state == S_DONE);
    assign o_div_result = r_result;

endmodule

// File: tb/tb_riscv_core_divider.sv
`timescale 1ns/1ps
// Directed self-checking bench for riscv_core_divider: values, latency, flush, busy-drop, reset.
module tb_riscv_core_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 65;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_div_start = 1'b0;
    logic [63:0] i_div_srcA = '0;
    logic [63:0] i_div_srcB = '0;
    logic [1:0]  i_div_op = '0;
    logic        i_div_isword = 1'b0;
    logic        i_div_flush = 1'b0;
    logic        o_div_busy;
    logic        o_div_valid;
    logic [63:0] o_div_result;

    int n_total = 0;
    int n_bad   = 0;

    riscv_core_divider #(.XLEN(64)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_div_start  (i_div_start),
        .i_div_srcA   (i_div_srcA),
        .i_div_srcB   (i_div_srcB),
        .i_div_op     (i_div_op),
        .i_div_isword (i_div_isword),
        .i_div_flush  (i_div_flush),
        .o_div_busy   (o_div_busy),
        .o_div_valid  (o_div_valid),
        .o_div_result (o_div_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [1:0] op, input logic isword,
                           input logic [63:0] a, input logic [63:0] b);
        i_div_op     = op;
        i_div_isword = isword;
        i_div_srcA   = a;
        i_div_srcB   = b;
        i_div_start  = 1'b1;
    endtask

    // Issue one op and count cycles after the start edge until valid (bounded).
    task automatic do_div(input string tag, input logic [1:0] op, input logic isword,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int  lat;
        bit  got;
        @(negedge i_clk);
        present(op, isword, a, b);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 100) begin
            @(negedge i_clk);
            if (o_div_valid) got = 1'b1;
            else begin
                @(posedge i_clk);
                lat++;
            end
        end
        check({tag, "_result"}, o_div_result, exp);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        bit seen;
        int waited;

        #12;
        check("reset_busy", {63'b0, o_div_busy}, 64'd0);
        check("reset_valid", {63'b0, o_div_valid}, 64'd0);
        check("reset_result", o_div_result, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        do_div("div_m20_3",   OP_DIV,  1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFA, 65);
        do_div("rem_m20_3",   OP_REM,  1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFE, 65);

        // Flush in cycle 10 of a full-width DIV.
        @(negedge i_clk);
        present(OP_DIV, 1'b0, 64'd1000, 64'd3);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1 i_div_flush = 1'b1;
        @(negedge i_clk);
        check("flush_busy_c10", {63'b0, o_div_busy}, 64'd1);
        @(posedge i_clk);
        #1 i_div_flush = 1'b0;
        @(negedge i_clk);
        check("flush_busy_c11", {63'b0, o_div_busy}, 64'd0);
        check("flush_valid_c11", {63'b0, o_div_valid}, 64'd0);
        check("flush_result_kept", o_div_result, 64'hFFFFFFFFFFFFFFFE);
        seen = 1'b0;
        repeat (70) begin
            @(negedge i_clk);
            if (o_div_valid) seen = 1'b1;
        end
        check("flush_no_valid", {63'b0, seen}, 64'd0);

        do_div("divu_big_2",  OP_DIVU, 1'b0, 64'h8000000000000000, 64'd2, 64'h4000000000000000, 65);
        do_div("remu_7_0",    OP_REMU, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        do_div("divu_7_0",    OP_DIVU, 1'b0, 64'd7, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
        do_div("div_ovf",     OP_DIV,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        do_div("rem_ovf",     OP_REM,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1);
        do_div("divw_ovf",    OP_DIV,  1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 1);
        do_div("divuw",       OP_DIVU, 1'b1, 64'hDEADBEEFFFFFFFFE, 64'd2, 64'h000000007FFFFFFF, 33);
        do_div("remw_m7_2",   OP_REM,  1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33);
        do_div("divuw_sext",  OP_DIVU, 1'b1, 64'h12345678FFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 33);
        do_div("remuw_f",     OP_REMU, 1'b1, 64'h00000000FFFFFFFF, 64'h10, 64'h000000000000000F, 33);
        do_div("divu_3_10",   OP_DIVU, 1'b0, 64'd3, 64'd10, 64'd0, EARLY_LAT);
        do_div("rem_m7_20",   OP_REM,  1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd20, 64'hFFFFFFFFFFFFFFF9, EARLY_LAT);

        // Starts while busy (mid-CALC and in DONE) are dropped, not queued.
        @(negedge i_clk);
        present(OP_DIVU, 1'b0, 64'd100, 64'd7);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 present(OP_DIVU, 1'b0, 64'd3, 64'd10);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        waited = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (!o_div_valid && waited < 100);
        check("busy_ign_valid", {63'b0, o_div_valid}, 64'd1);
        check("busy_ign_result", o_div_result, 64'd14);
        present(OP_DIVU, 1'b0, 64'd50, 64'd5);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        @(negedge i_clk);
        check("done_start_busy", {63'b0, o_div_busy}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge i_clk);
            if (o_div_valid) seen = 1'b1;
        end
        check("start_not_queued", {63'b0, seen}, 64'd0);
        check("result_held", o_div_result, 64'd14);
        do_div("after_drop",  OP_DIVU, 1'b0, 64'd50, 64'd5, 64'd10, 65);

        // Asynchronous reset in the middle of CALC.
        @(negedge i_clk);
        present(OP_DIV, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3);
        @(posedge i_clk);
        #1 i_div_start = 1'b0;
        repeat (20) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'b0, o_div_busy}, 64'd0);
        check("rst_mid_valid", {63'b0, o_div_valid}, 64'd0);
        check("rst_mid_result", o_div_result, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        do_div("after_reset", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
